// File: rtl/sumador_pipe.sv
// ============================================================================
// Module   : sumador_pipe
// Brief    : Two-stage pipelined signed adder/subtractor with valid/ready
//            handshake and {N,Z,C,V} flags. Define SUMADOR_SAT_EN for signed
//            saturation of the result on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sumador_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic [3:0]       flags
);

  localparam int c_half = WIDTH / 2;

`ifdef SUMADOR_SAT_EN
  localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // stage 1 state
  logic              r_s1_valid;
  logic [c_half-1:0] r_s1_lo;
  logic              r_s1_c;
  logic [c_half-1:0] r_s1_ahi;
  logic [c_half-1:0] r_s1_bhi;
  logic              r_s1_op;

  // stage 2 state (drives the outputs directly)
  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_s;
  logic [3:0]        r_flags;

  logic              w_adv;
  logic              w_accept;
  logic [c_half-1:0] w_b_lo;
  logic [c_half:0]   w_lo_sum;
  logic [c_half-1:0] w_b_hi;
  logic [c_half:0]   w_hi_sum;
  logic [WIDTH-1:0]  w_wrap;
  logic              w_c;
  logic              w_v;
  logic [WIDTH-1:0]  w_res;
  logic [3:0]        w_flags;

  // Stage 2 frees up when empty or when its beat is being taken.
  assign w_adv    = !r_s2_valid || out_ready;
  assign in_ready = !rst && (!r_s1_valid || w_adv);
  assign w_accept = in_valid && in_ready;

  // Low half: subtraction folds in as A + ~B + 1, the +1 entering as carry-in.
  assign w_b_lo   = op ? ~B[c_half-1:0] : B[c_half-1:0];
  assign w_lo_sum = {1'b0, A[c_half-1:0]} + {1'b0, w_b_lo} + {{c_half{1'b0}}, op};

  // Upper half completes from the registered low-half carry.
  assign w_b_hi   = r_s1_op ? ~r_s1_bhi : r_s1_bhi;
  assign w_hi_sum = {1'b0, r_s1_ahi} + {1'b0, w_b_hi} + {{c_half{1'b0}}, r_s1_c};
  assign w_wrap   = {w_hi_sum[c_half-1:0], r_s1_lo};
  assign w_c      = w_hi_sum[c_half];
  assign w_v      = (r_s1_ahi[c_half-1] == w_b_hi[c_half-1]) &&
                    (w_wrap[WIDTH-1] != r_s1_ahi[c_half-1]);

`ifdef SUMADOR_SAT_EN
  // Clamp toward the sign of A; V still reports the overflow.
  assign w_res = w_v ? (r_s1_ahi[c_half-1] ? c_min_neg : c_max_pos) : w_wrap;
`else
  assign w_res = w_wrap;
`endif

  assign w_flags = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_c     <= 1'b0;
      r_s1_ahi   <= '0;
      r_s1_bhi   <= '0;
      r_s1_op    <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s        <= '0;
      r_flags    <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_lo    <= w_lo_sum[c_half-1:0];
        r_s1_c     <= w_lo_sum[c_half];
        r_s1_ahi   <= A[WIDTH-1:c_half];
        r_s1_bhi   <= B[WIDTH-1:c_half];
        r_s1_op    <= op;
      end else if (w_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s     <= w_res;
          r_flags <= w_flags;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign S         = r_s;
  assign flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_sumador_pipe.sv
// ============================================================================
// Module   : tb_sumador_pipe
// Brief    : Directed self-checking bench for sumador_pipe (WIDTH 32 and 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sumador_pipe;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid32, in_ready32, op32, out_valid32, out_ready32;
  logic [31:0] a32, b32, s32;
  logic [3:0]  flags32;

  logic        in_valid8, in_ready8, op8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, s8;
  logic [3:0]  flags8;

  int n_total = 0;
  int n_bad   = 0;

  sumador_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .op(op32), .out_valid(out_valid32),
    .out_ready(out_ready32), .S(s32), .flags(flags32)
  );

  sumador_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .op(op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .S(s8), .flags(flags8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat through the 32-bit pipe: accept, one empty cycle, result, drained.
  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [31:0] exp_s, input logic [3:0] exp_f);
    @(negedge clk);
    in_valid32 = 1'b1; a32 = a; b32 = b; op32 = o; out_ready32 = 1'b1;
    #1 check({tag, "_rdy"}, in_ready32, 1);
    @(negedge clk);
    in_valid32 = 1'b0;
    check({tag, "_lat1"}, out_valid32, 0);
    @(negedge clk);
    check({tag, "_vld"}, out_valid32, 1);
    check({tag, "_s"}, s32, exp_s);
    check({tag, "_f"}, flags32, exp_f);
    @(negedge clk);
    check({tag, "_drain"}, out_valid32, 0);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic o, input logic [7:0] exp_s, input logic [3:0] exp_f);
    @(negedge clk);
    in_valid8 = 1'b1; a8 = a; b8 = b; op8 = o; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    check({tag, "_lat1"}, out_valid8, 0);
    @(negedge clk);
    check({tag, "_vld"}, out_valid8, 1);
    check({tag, "_s"}, s8, exp_s);
    check({tag, "_f"}, flags8, exp_f);
  endtask

  logic [31:0] st_a [8] = '{32'd10, 32'd100, 32'h0000FFFF, 32'd1,
                            32'h12340000, 32'd50, 32'd7, 32'h00010000};
  logic [31:0] st_b [8] = '{32'd20, 32'd1, 32'd1, 32'd2,
                            32'h00005678, 32'd50, 32'd8, 32'd1};
  logic        st_o [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] st_s [8] = '{32'd30, 32'd99, 32'h00010000, 32'hFFFFFFFF,
                            32'h12345678, 32'd0, 32'd15, 32'h0000FFFF};

  initial begin
    int tx;
    int rx;
    logic [31:0] held;

    rst = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; op32 = 1'b0; out_ready32 = 1'b1;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; op8  = 1'b0; out_ready8  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vld", out_valid32, 0);
    check("rst_s", s32, 0);
    check("rst_f", flags32, 0);
    check("rst_rdy", in_ready32, 0);
    check("rst_rdy8", in_ready8, 0);
    rst = 1'b0;

    run32("add5_7",   32'd5,        32'd7, 1'b0, 32'd12,       4'b0000);
    run32("sub3_3",   32'd3,        32'd3, 1'b1, 32'd0,        4'b0110);
`ifdef SUMADOR_SAT_EN
    run32("ovf_pos",  32'h7FFFFFFF, 32'd1, 1'b0, 32'h7FFFFFFF, 4'b0001);
    run32("ovf_neg",  32'h80000000, 32'd1, 1'b1, 32'h80000000, 4'b1011);
`else
    run32("ovf_pos",  32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 4'b1001);
    run32("ovf_neg",  32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 4'b0011);
`endif
    run32("carry_all",32'hFFFFFFFF, 32'd1, 1'b0, 32'd0,        4'b0110);
    run32("sub_brw",  32'd2,        32'd5, 1'b1, 32'hFFFFFFFD, 4'b1000);
    run32("lo_carry", 32'h0000FFFF, 32'd1, 1'b0, 32'h00010000, 4'b0000);

    run8("w8_carry",  8'h0F, 8'h01, 1'b0, 8'h10, 4'b0000);
    run8("w8_sub",    8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000);
`ifdef SUMADOR_SAT_EN
    run8("w8_ovf",    8'h7F, 8'h01, 1'b0, 8'h7F, 4'b0001);
`else
    run8("w8_ovf",    8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001);
`endif

    // Back-to-back stream with the consumer stalled for cycles 3..5.
    tx = 0; rx = 0; held = '0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready32 = !(cyc >= 3 && cyc <= 5);
      if (tx < 8) begin
        in_valid32 = 1'b1; a32 = st_a[tx]; b32 = st_b[tx]; op32 = st_o[tx];
      end else begin
        in_valid32 = 1'b0;
      end
      #1;
      if (cyc == 3) begin
        check("stall_rdy", in_ready32, 0);
        held = s32;
      end
      if (cyc == 4 || cyc == 5) begin
        check("stall_vld", out_valid32, 1);
        check("stall_s", s32, held);
      end
      if (out_valid32 && out_ready32) begin
        check($sformatf("stream_s%0d", rx), s32, st_s[rx]);
        rx++;
      end
      if (in_valid32 && in_ready32) tx++;
    end
    check("stream_count", rx, 8);
    @(negedge clk);
    in_valid32 = 1'b0;
    #1 check("stream_tail", out_valid32, 0);

    // Reset with two beats in flight, then an immediate new beat.
    @(negedge clk);
    out_ready32 = 1'b0; in_valid32 = 1'b1; a32 = 32'd1; b32 = 32'd1; op32 = 1'b0;
    @(negedge clk);
    a32 = 32'd2; b32 = 32'd2;
    @(negedge clk);
    in_valid32 = 1'b0;
    check("pre_rst_vld", out_valid32, 1);
    rst = 1'b1;
    #1 check("rst_mid_rdy", in_ready32, 0);
    @(negedge clk);
    check("rst_mid_vld", out_valid32, 0);
    check("rst_mid_s", s32, 0);
    check("rst_mid_f", flags32, 0);
    rst = 1'b0; out_ready32 = 1'b1;
    in_valid32 = 1'b1; a32 = 32'd40; b32 = 32'd2; op32 = 1'b0;
    #1 check("post_rst_rdy", in_ready32, 1);
    @(negedge clk);
    in_valid32 = 1'b0;
    check("post_rst_lat1", out_valid32, 0);
    @(negedge clk);
    check("post_rst_vld", out_valid32, 1);
    check("post_rst_s", s32, 32'd42);
    @(negedge clk);
    check("post_rst_drain", out_valid32, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sumador_pipe.md
SUMADOR_PIPE -- requirements
Module: sumador_pipe

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, meaning operand/result width in bits (even, >= 4).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  operand beat offered.
REQ-005 The block SHALL have port in_ready  output  1  block accepts operand beat this cycle.
REQ-006 The block SHALL have port A  input  WIDTH  signed operand 1.
REQ-007 The block SHALL have port B  input  WIDTH  signed operand 2 or immediate.
REQ-008 The block SHALL have port op  input  1  0 = A+B, 1 = A-B.
REQ-009 The block SHALL have port out_valid  output  1  result beat present.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result beat.
REQ-011 The block SHALL have port S  output  WIDTH  result, S = (A op B) mod 2^WIDTH.
REQ-012 The block SHALL have port flags  output  4  {N,Z,C,V} for S.

Function
REQ-013 Accept occurs when in_valid && in_ready; deliver occurs when out_valid && out_ready.
REQ-014 Two register stages SHALL be used: stage 1 registers low-half sum (WIDTH/2 bits), low-half carry-out, upper operand halves, op; stage 2 completes upper half and flags.
REQ-015 Latency SHALL be exactly 2 cycles from accept to out_valid when out_ready stays high.
REQ-016 Subtraction SHALL be A + ~B + 1; C = carry-out of MSB (1 = no borrow).
REQ-017 V SHALL be 1 when operand signs (B inverted for sub) are equal and S sign differs; N = S[WIDTH-1]; Z = (S == 0).
REQ-018 Stage 2 SHALL load when empty or delivering; stage 1 SHALL advance under the same condition.
REQ-019 in_ready SHALL be 1 when stage 1 empty or stage 1 advancing this cycle (combinational from out_ready allowed).
REQ-020 With both stages full and out_ready low, in_ready SHALL be 0 and S/flags/out_valid SHALL hold stable.
REQ-021 Simultaneous accept and deliver with both stages full SHALL sustain throughput of 1 result/cycle with no bubble.
REQ-022 Results SHALL exit in accept order; no beat duplicated or dropped.
REQ-023 in_valid low SHALL insert bubbles; out_valid low SHALL be asserted for corresponding cycles.

Reset
REQ-024 While rst = 1 at a clk edge, both stage valid bits SHALL clear; out_valid = 0, S = 0, flags = 4'b0000 after the edge.
REQ-025 in_ready SHALL be 0 during cycles rst is high; in-flight beats SHALL be discarded on reset mid-operation.
REQ-026 First accept SHALL be possible the cycle after rst deasserts.

Configuration
REQ-027 Macro SUMADOR_SAT_EN SHALL enable signed saturation of S.
REQ-028 With SUMADOR_SAT_EN defined: on V = 1, S SHALL be max positive (0111..1) if A is non-negative, else min negative (1000..0); V still reports 1; N/Z computed from saturated S.
REQ-029 Without SUMADOR_SAT_EN: S SHALL be wrapped result; no saturation logic present.

Verification
REQ-030 WIDTH=32, op=0, A=5, B=7, out_ready=1 -> two cycles later S=12, flags=0000.
REQ-031 op=1, A=3, B=3 -> S=0, flags Z=1, C=1, N=0, V=0.
REQ-032 A=0x7FFFFFFF, B=1, op=0 -> V=1, N=1, S=0x80000000 (wrap); with SUMADOR_SAT_EN S=0x7FFFFFFF, N=0.
REQ-033 Stream 8 back-to-back beats, out_ready low for cycles 3-5 -> in_ready drops after both stages fill, results in order, none lost, S stable while stalled.
REQ-034 Assert rst with 2 beats in flight -> out_valid=0 next cycle, those beats never delivered; new beat after reset delivered at latency 2.
REQ-035 WIDTH=8, A=0x0F, B=0x01, op=0 -> low-half carry propagates, S=0x10, C=0, V=0.
